// File: rtl/ppu_pixel_stream.sv
// Purpose : buffers PPU pixel writes and re-emits them as a framed pixel stream; optional per-frame index sum (PPU_PIXEL_SUM_EN).
// Latency : one cycle from pop decision to registered pixel/pixel_en; at least GAP_CYC idle cycles between frame and the first pixel_en.
// Backpressure: out_ready=0 holds the FIFO head; writes into a full FIFO are dropped and set sticky overflow.
`timescale 1ns/1ps
module ppu_pixel_stream #(
    parameter int IMAGE_W    = 256,
    parameter int IMAGE_H    = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYC    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_px,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        out_ready,
    output logic [7:0]  pixel,
    output logic        pixel_en,
    output logic        frame,
    output logic [8:0]  px_x,
    output logic [7:0]  px_y,
    output logic [15:0] frame_cnt,
    output logic        overflow,
    output logic        short_frame,
    output logic [15:0] frame_sum
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CNTW     = AW + 1;
    localparam int TOTAL    = IMAGE_W * IMAGE_H;
    localparam int CW       = $clog2(TOTAL + 1);
    localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    // The pop cycle in STREAM is itself idle, so GAP only needs GAP_CYC-1 cycles.
    localparam int GAP_LAST = (GAP_CYC > 1) ? GAP_CYC - 2 : 0;

    localparam logic [CW-1:0]   TOTAL_C    = CW'(TOTAL);
    localparam logic [CW-1:0]   LAST_C     = CW'(TOTAL - 1);
    localparam logic [8:0]      X_LAST     = 9'(IMAGE_W - 1);
    localparam logic [7:0]      Y_LAST     = 8'(IMAGE_H - 1);
    localparam logic [GW-1:0]   GAP_LAST_C = GW'(GAP_LAST);
    localparam logic [CNTW-1:0] FULL_C     = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_STREAM} state_t;

    // FIFO storage: entry is {sof, px}
    logic [8:0]      fifo_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            overflow_q;

    logic fifo_empty, fifo_full, head_sof;
    logic [7:0] head_px;
    logic push, pop, emit, go_pulse;

    // Output FSM state and registered outputs
    state_t      state_q;
    logic [GW-1:0] gap_q;
    logic [CW-1:0] pix_cnt_q;
    logic [8:0]  nx_q, px_x_q;
    logic [7:0]  ny_q, px_y_q;
    logic [7:0]  pixel_q;
    logic        pixel_en_q, frame_q, short_q;
    logic [15:0] frame_cnt_q;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_C);
    assign head_sof   = fifo_q[rd_ptr_q][8];
    assign head_px    = fifo_q[rd_ptr_q][7:0];

    // Pop/emit/pulse decisions from current state and FIFO head
    always_comb begin
        pop      = 1'b0;
        emit     = 1'b0;
        go_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_sof) go_pulse = 1'b1;
                    else          pop      = 1'b1;
                end
            end
            S_STREAM: begin
                if (!fifo_empty && head_sof && (pix_cnt_q != '0)) begin
                    go_pulse = 1'b1;
                end else if (!fifo_empty && out_ready) begin
                    pop  = 1'b1;
                    emit = 1'b1;
                end
            end
            default: ;
        endcase
        // A pop in the same cycle frees a slot, so a write into a full FIFO is kept.
        push = in_valid && (!fifo_full || pop);
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointers, storage, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {in_sof, in_px};
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
            if (in_valid && !push) overflow_q <= 1'b1;
        end
    end

    // Output FSM with registered pixel, position and frame outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            pix_cnt_q   <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            px_x_q      <= '0;
            px_y_q      <= '0;
            pixel_q     <= '0;
            pixel_en_q  <= 1'b0;
            frame_q     <= 1'b0;
            short_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            frame_q    <= 1'b0;
            pixel_en_q <= 1'b0;
            if (go_pulse) begin
                if ((state_q == S_STREAM) && (pix_cnt_q < TOTAL_C)) short_q <= 1'b1;
                state_q     <= S_PULSE;
                frame_q     <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                px_x_q      <= '0;
                px_y_q      <= '0;
                nx_q        <= '0;
                ny_q        <= '0;
                pix_cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_PULSE: begin
                        gap_q   <= '0;
                        state_q <= (GAP_CYC > 1) ? S_GAP : S_STREAM;
                    end
                    S_GAP: begin
                        if (gap_q == GAP_LAST_C) state_q <= S_STREAM;
                        else                     gap_q   <= gap_q + GW'(1);
                    end
                    S_STREAM: begin
                        if (emit) begin
                            pixel_q    <= head_px;
                            pixel_en_q <= 1'b1;
                            px_x_q     <= nx_q;
                            px_y_q     <= ny_q;
                            // Past the last raster position, hold the final coordinates.
                            if (pix_cnt_q < LAST_C) begin
                                if (nx_q == X_LAST) begin
                                    nx_q <= '0;
                                    if (ny_q != Y_LAST) ny_q <= ny_q + 8'd1;
                                end else begin
                                    nx_q <= nx_q + 9'd1;
                                end
                            end
                            if (pix_cnt_q != TOTAL_C) pix_cnt_q <= pix_cnt_q + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PPU_PIXEL_SUM_EN
    logic [15:0] acc_q, frame_sum_q;

    // Per-frame sum of palette indices, latched and cleared at each frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            frame_sum_q <= '0;
        end else if (go_pulse) begin
            frame_sum_q <= acc_q;
            acc_q       <= '0;
        end else if (emit) begin
            acc_q <= acc_q + {10'b0, head_px[5:0]};
        end
    end

    assign frame_sum = frame_sum_q;
`else
    assign frame_sum = '0;
`endif

    assign pixel       = pixel_q;
    assign pixel_en    = pixel_en_q;
    assign frame       = frame_q;
    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign frame_cnt   = frame_cnt_q;
    assign overflow    = overflow_q;
    assign short_frame = short_q;

endmodule

// File: tb/tb_ppu_pixel_stream.sv
// Directed bench for ppu_pixel_stream with a 4x2 image, 4-entry FIFO and 2-cycle gap.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// Expected values are hand-derived cycle by cycle from the stream's behaviour.
`timescale 1ns/1ps
module tb_ppu_pixel_stream;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_px;
    logic        in_valid;
    logic        in_sof;
    logic        out_ready;
    logic [7:0]  pixel;
    logic        pixel_en;
    logic        frame;
    logic [8:0]  px_x;
    logic [7:0]  px_y;
    logic [15:0] frame_cnt;
    logic        overflow;
    logic        short_frame;
    logic [15:0] frame_sum;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PPU_PIXEL_SUM_EN
    localparam int SUM1 = 36;   // indices 1..8
    localparam int SUM2 = 95;   // indices 0x11..0x15
`else
    localparam int SUM1 = 0;
    localparam int SUM2 = 0;
`endif

    ppu_pixel_stream #(
        .IMAGE_W   (4),
        .IMAGE_H   (2),
        .FIFO_DEPTH(4),
        .GAP_CYC   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_px      (in_px),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .out_ready  (out_ready),
        .pixel      (pixel),
        .pixel_en   (pixel_en),
        .frame      (frame),
        .px_x       (px_x),
        .px_y       (px_y),
        .frame_cnt  (frame_cnt),
        .overflow   (overflow),
        .short_frame(short_frame),
        .frame_sum  (frame_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_px(input string tag, input logic en, input logic [7:0] p, input int x, input int y);
        chk({tag, ".en"}, {31'b0, pixel_en}, {31'b0, en});
        chk({tag, ".px"}, {24'b0, pixel}, {24'b0, p});
        chk({tag, ".x"},  {23'b0, px_x}, x);
        chk({tag, ".y"},  {24'b0, px_y}, y);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".en"},    {31'b0, pixel_en}, 0);
        chk({tag, ".frame"}, {31'b0, frame}, 0);
    endtask

    // Drive one cycle of inputs, then land 1 ns after the next rising edge.
    task automatic cyc(input logic v, input logic s, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_sof    = s;
        in_px     = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".en"},    {31'b0, pixel_en}, 0);
        chk({tag, ".px"},    {24'b0, pixel}, 0);
        chk({tag, ".frame"}, {31'b0, frame}, 0);
        chk({tag, ".x"},     {23'b0, px_x}, 0);
        chk({tag, ".y"},     {24'b0, px_y}, 0);
        chk({tag, ".fcnt"},  {16'b0, frame_cnt}, 0);
        chk({tag, ".ovf"},   {31'b0, overflow}, 0);
        chk({tag, ".short"}, {31'b0, short_frame}, 0);
        chk({tag, ".sum"},   {16'b0, frame_sum}, 0);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_px = 8'h00; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        all_zero("rst0");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic frame: 0x01(sof)..0x08
        cyc(1, 1, 8'h01, 1); idle_chk("b.e1");
        cyc(1, 0, 8'h02, 1);
        chk("b.frame", {31'b0, frame}, 1);
        chk("b.en_pulse", {31'b0, pixel_en}, 0);
        chk("b.fcnt", {16'b0, frame_cnt}, 1);
        chk("b.sum0", {16'b0, frame_sum}, 0);
        cyc(1, 0, 8'h03, 1); idle_chk("b.gap1");
        cyc(1, 0, 8'h04, 1); idle_chk("b.gap2");
        cyc(0, 0, 8'h00, 1); chk_px("b01", 1, 8'h01, 0, 0);
        cyc(1, 0, 8'h05, 1); chk_px("b02", 1, 8'h02, 1, 0);
        cyc(1, 0, 8'h06, 1); chk_px("b03", 1, 8'h03, 2, 0);
        cyc(1, 0, 8'h07, 1); chk_px("b04", 1, 8'h04, 3, 0);
        cyc(1, 0, 8'h08, 1); chk_px("b05", 1, 8'h05, 0, 1);
        cyc(0, 0, 8'h00, 1); chk_px("b06", 1, 8'h06, 1, 1);
        cyc(0, 0, 8'h00, 1); chk_px("b07", 1, 8'h07, 2, 1);
        cyc(0, 0, 8'h00, 1); chk_px("b08", 1, 8'h08, 3, 1);
        cyc(0, 0, 8'h00, 1); chk_px("b.hold", 0, 8'h08, 3, 1);
        chk("b.ovf", {31'b0, overflow}, 0);
        chk("b.short", {31'b0, short_frame}, 0);

        // Second frame of 5 pixels, cut short by a third sof
        cyc(1, 1, 8'h11, 1); idle_chk("c.e1");
        cyc(1, 0, 8'h12, 1);
        chk("c.frame", {31'b0, frame}, 1);
        chk("c.fcnt", {16'b0, frame_cnt}, 2);
        chk("c.sum", {16'b0, frame_sum}, SUM1);
        chk("c.short0", {31'b0, short_frame}, 0);
        chk("c.x0", {23'b0, px_x}, 0);
        chk("c.y0", {24'b0, px_y}, 0);
        cyc(1, 0, 8'h13, 1); idle_chk("c.gap1");
        cyc(1, 0, 8'h14, 1); idle_chk("c.gap2");
        cyc(0, 0, 8'h00, 1); chk_px("c11", 1, 8'h11, 0, 0);
        cyc(1, 0, 8'h15, 1); chk_px("c12", 1, 8'h12, 1, 0);
        cyc(1, 1, 8'h21, 1); chk_px("c13", 1, 8'h13, 2, 0);
        cyc(0, 0, 8'h00, 1); chk_px("c14", 1, 8'h14, 3, 0);
        cyc(0, 0, 8'h00, 1); chk_px("c15", 1, 8'h15, 0, 1);
        cyc(0, 0, 8'h00, 1);
        chk("c.frame2", {31'b0, frame}, 1);
        chk("c.en_pulse2", {31'b0, pixel_en}, 0);
        chk("c.short1", {31'b0, short_frame}, 1);
        chk("c.fcnt3", {16'b0, frame_cnt}, 3);
        chk("c.sum2", {16'b0, frame_sum}, SUM2);
        chk("c.x_rst", {23'b0, px_x}, 0);
        chk("c.y_rst", {24'b0, px_y}, 0);
        cyc(0, 0, 8'h00, 1); idle_chk("c.gap3");
        cyc(0, 0, 8'h00, 1); idle_chk("c.gap4");
        cyc(0, 0, 8'h00, 1); chk_px("c21", 1, 8'h21, 0, 0);

        // Backpressure: 6 writes with out_ready low, only 4 fit
        cyc(1, 0, 8'h31, 0); chk_px("d.w1", 0, 8'h21, 0, 0);
        cyc(1, 0, 8'h32, 0);
        cyc(1, 0, 8'h33, 0);
        cyc(1, 0, 8'h34, 0); chk("d.ovf0", {31'b0, overflow}, 0);
        cyc(1, 0, 8'h35, 0); chk("d.ovf1", {31'b0, overflow}, 1);
        cyc(1, 0, 8'h36, 0); chk_px("d.w6", 0, 8'h21, 0, 0);
        cyc(0, 0, 8'h00, 1); chk_px("d31", 1, 8'h31, 1, 0);
        cyc(0, 0, 8'h00, 1); chk_px("d32", 1, 8'h32, 2, 0);
        cyc(0, 0, 8'h00, 1); chk_px("d33", 1, 8'h33, 3, 0);
        cyc(0, 0, 8'h00, 1); chk_px("d34", 1, 8'h34, 0, 1);
        cyc(0, 0, 8'h00, 1); chk("d.drained", {31'b0, pixel_en}, 0);
        chk("d.ovf_sticky", {31'b0, overflow}, 1);

        // Asynchronous reset in the middle of streaming
        cyc(1, 0, 8'h41, 1); chk("e.en0", {31'b0, pixel_en}, 0);
        cyc(1, 0, 8'h42, 1); chk_px("e41", 1, 8'h41, 1, 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        all_zero("rst1");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pre-sof garbage is discarded; output resumes at the sof pixel
        cyc(1, 0, 8'h51, 1); idle_chk("g.51");
        cyc(1, 0, 8'h52, 1); idle_chk("g.52");
        cyc(1, 0, 8'h53, 1); idle_chk("g.53");
        cyc(1, 1, 8'h61, 1); idle_chk("g.sof");
        cyc(1, 0, 8'h62, 1);
        chk("g.frame", {31'b0, frame}, 1);
        chk("g.fcnt", {16'b0, frame_cnt}, 1);
        chk("g.sum", {16'b0, frame_sum}, 0);
        chk("g.en_pulse", {31'b0, pixel_en}, 0);
        cyc(0, 0, 8'h00, 1); idle_chk("g.gap1");
        cyc(0, 0, 8'h00, 1); idle_chk("g.gap2");
        cyc(0, 0, 8'h00, 1); chk_px("g61", 1, 8'h61, 0, 0);
        cyc(0, 0, 8'h00, 1); chk_px("g62", 1, 8'h62, 1, 0);
        chk("g.ovf", {31'b0, overflow}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
